// File: rtl/data_memory_ext.sv
// data_memory_ext: fixed-latency word memory with byte/half/word loads and stores,
// sign/zero extension, alignment checking and a req/ready/done handshake.
// Ports: clk, reset_n (async active-low); req/ready request handshake;
// MemRead/MemWrite/size/unsigned_ld/address/writeData describe the access;
// readData (extended load result), done (1-cycle completion), error (valid with done).
module data_memory_ext #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  output logic        ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        done,
  output logic        error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_rd, r_wr, r_uns, r_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        w_accept, w_fire, w_sel, w_rd, w_wr, w_uns, w_err;
  logic [1:0]  w_size;
  logic [31:0] w_addr, w_wdata, w_word, w_sh, w_ext, w_wd;
  logic [3:0]  w_be;
  logic [AW-1:0] w_idx;
  assign w_accept = r_state == IDLE && req;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = (LATENCY == 1) ? DONE : WAIT;
    else if (r_state == WAIT && r_cnt == 4'd1) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  // DONE always falls back to IDLE, so entering DONE is exactly "next is DONE".
  assign w_fire = w_next == DONE;
  // With LATENCY=1 the access completes on its acceptance edge, so use live inputs then.
  assign w_sel   = r_state == IDLE;
  assign w_rd    = w_sel ? MemRead     : r_rd;
  assign w_wr    = w_sel ? MemWrite    : r_wr;
  assign w_size  = w_sel ? size        : r_size;
  assign w_uns   = w_sel ? unsigned_ld : r_uns;
  assign w_addr  = w_sel ? address     : r_addr;
  assign w_wdata = w_sel ? writeData   : r_wdata;
  // Truncating the word address gives wrap-around on the high bits.
  assign w_idx  = AW'(w_addr >> 2);
  assign w_err  = (w_size == 2'b11) || (w_size == 2'b01 && w_addr[0]) ||
                  (w_size == 2'b10 && w_addr[1:0] != 2'b00) || (w_rd && w_wr);
  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {w_addr[1:0], 3'b000};
  assign w_ext  = (w_size == 2'b00) ? {{24{~w_uns & w_sh[7]}}, w_sh[7:0]} :
                  (w_size == 2'b01) ? {{16{~w_uns & w_sh[15]}}, w_sh[15:0]} : w_word;
  assign w_be   = (w_size == 2'b00) ? 4'b0001 << w_addr[1:0] :
                  (w_size == 2'b01) ? 4'b0011 << {w_addr[1], 1'b0} : 4'b1111;
  assign w_wd   = (w_size == 2'b00) ? {4{w_wdata[7:0]}} :
                  (w_size == 2'b01) ? {2{w_wdata[15:0]}} : w_wdata;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= (LATENCY == 1) ? 4'd0 : 4'(LATENCY - 1);
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_size  <= size;
        r_uns   <= unsigned_ld;
        r_addr  <= address;
        r_wdata <= writeData;
      end else if (r_state == WAIT) r_cnt <= r_cnt - 4'd1;
      if (w_fire) begin
        r_err   <= w_err;
        r_rdata <= (!w_err && w_rd) ? w_ext : 32'd0;
      end
    end
  end
  // Memory has no reset; the reset_n gate keeps an edge during reset from writing.
  always_ff @(posedge clk) begin
    if (reset_n && w_fire && w_wr && !w_err)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
  end
  assign ready    = r_state == IDLE;
  assign done     = r_state == DONE;
  assign error    = done & r_err;
  assign readData = r_rdata;
endmodule

// File: tb/tb_data_memory_ext.sv
// tb_data_memory_ext: directed table-driven bench for data_memory_ext.
module tb_data_memory_ext;
  localparam int LAT = 2;
  logic clk = 1'b0, reset_n = 1'b0, req = 1'b0, ready, done, error;
  logic MemRead = 1'b0, MemWrite = 1'b0, unsigned_ld = 1'b0;
  logic [1:0] size = 2'b00;
  logic [31:0] address = 32'd0, writeData = 32'd0, readData;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  data_memory_ext #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ready(ready), .MemRead(MemRead),
    .MemWrite(MemWrite), .size(size), .unsigned_ld(unsigned_ld), .address(address),
    .writeData(writeData), .readData(readData), .done(done), .error(error));
  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wd, exp_data;
    logic        exp_err;
  } vec_t;
  vec_t v[23];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic access(input vec_t t, output logic [31:0] rdata, output logic err, output int lat);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; MemRead = t.rd; MemWrite = t.wr; size = t.sz; unsigned_ld = t.uns;
    address = t.addr; writeData = t.wd;
    @(posedge clk);
    #1 req = 1'b0;
    MemRead = ~t.rd; MemWrite = ~t.wr; address = ~t.addr; writeData = ~t.wd;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!done && lat < 20);
    rdata = readData;
    err = error;
  endtask
  task automatic run(input vec_t t, input string name);
    logic [31:0] d; logic e; int l;
    access(t, d, e, l);
    chk({name, "_data"}, d, t.exp_data);
    chk({name, "_err"}, 32'(e), 32'(t.exp_err));
    chk({name, "_lat"}, l, LAT);
  endtask
  function automatic vec_t mk(input logic rd, wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, wd, ed, input logic ee);
    vec_t t;
    t.rd = rd; t.wr = wr; t.sz = sz; t.uns = uns; t.addr = addr; t.wd = wd;
    t.exp_data = ed; t.exp_err = ee;
    return t;
  endfunction
  initial begin
    v[0]  = mk(0, 1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    v[1]  = mk(1, 0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    v[2]  = mk(0, 1, 2'b10, 0, 32'h10,  32'h0,        32'h0,        0);
    v[3]  = mk(0, 1, 2'b00, 0, 32'h13,  32'h12345680, 32'h0,        0);
    v[4]  = mk(1, 0, 2'b10, 0, 32'h10,  32'h0,        32'h80000000, 0);
    v[5]  = mk(1, 0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    v[6]  = mk(1, 0, 2'b00, 1, 32'h13,  32'h0,        32'h00000080, 0);
    v[7]  = mk(0, 1, 2'b10, 0, 32'h20,  32'hA5A55A5A, 32'h0,        0);
    v[8]  = mk(0, 1, 2'b01, 0, 32'h21,  32'h00001234, 32'h0,        1);
    v[9]  = mk(1, 0, 2'b10, 0, 32'h20,  32'h0,        32'hA5A55A5A, 0);
    v[10] = mk(1, 0, 2'b10, 0, 32'h22,  32'h0,        32'h0,        1);
    v[11] = mk(1, 0, 2'b01, 0, 32'h22,  32'h0,        32'hFFFFA5A5, 0);
    v[12] = mk(1, 0, 2'b01, 1, 32'h22,  32'h0,        32'h0000A5A5, 0);
    v[13] = mk(1, 0, 2'b01, 0, 32'h20,  32'h0,        32'h00005A5A, 0);
    v[14] = mk(0, 1, 2'b01, 0, 32'h22,  32'h7777BEEF, 32'h0,        0);
    v[15] = mk(1, 0, 2'b10, 0, 32'h20,  32'h0,        32'hBEEF5A5A, 0);
    v[16] = mk(1, 0, 2'b11, 0, 32'h20,  32'h0,        32'h0,        1);
    v[17] = mk(1, 1, 2'b10, 0, 32'h20,  32'h0,        32'h0,        1);
    v[18] = mk(1, 0, 2'b10, 0, 32'h20,  32'h0,        32'hBEEF5A5A, 0);
    v[19] = mk(0, 0, 2'b10, 0, 32'h20,  32'h0,        32'h0,        0);
    v[20] = mk(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,        0);
    v[21] = mk(1, 0, 2'b10, 0, 32'h0,   32'h0,        32'hCAFEF00D, 0);
    v[22] = mk(1, 0, 2'b00, 0, 32'h22,  32'h0,        32'hFFFFFFEF, 0);
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_rdata", readData, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 23; i++) run(v[i], $sformatf("vec%0d", i));
    // Back-pressure: req held high, writeData changing every cycle.
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("bp_ready%0d", k), 32'(ready), 32'(k % 3 == 0));
      chk($sformatf("bp_done%0d", k), 32'(done), 32'(k % 3 == 2));
      req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
      address = 32'h40; writeData = 32'h1000 + 32'(k);
    end
    @(negedge clk) req = 1'b0;
    chk("bp_idle", 32'(ready), 32'd1);
    run(mk(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h1006, 0), "bp_read");
    // Reset in the middle of a store.
    run(mk(0, 1, 2'b10, 0, 32'h30, 32'h11111111, 32'h0, 0), "rs_pre");
    run(mk(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h11111111, 0), "rs_chk");
    @(negedge clk);
    req = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; size = 2'b10; address = 32'h30;
    writeData = 32'h22222222;
    @(posedge clk);
    #1 req = 1'b0;
    chk("rs_wait_ready", 32'(ready), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("rs_ready", 32'(ready), 32'd1);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_rdata", readData, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rs_nodone%0d", k), 32'(done), 32'd0);
    end
    run(mk(1, 0, 2'b10, 0, 32'h30, 32'h0, 32'h11111111, 0), "rs_post");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
